// File: rtl/aximm_pkg.sv
// Shared AXI4 constants, reader FSM encodings and a bus-width helper.
// Latency: n/a (compile-time definitions only).
// Backpressure: n/a.
package aximm_pkg;

  localparam logic [1:0] AXI_BURST_INCR    = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY     = 2'b00;
  localparam logic [3:0] AXI_CACHE_DEFAULT = 4'b0011;

  // Reader FSM encodings, kept as plain vectors so older tools and
  // waveform scripts that decode the raw state value keep working.
  typedef logic [2:0] rd_state_t;
  localparam rd_state_t ST_IDLE = 3'd0;
  localparam rd_state_t ST_CALC = 3'd1;
  localparam rd_state_t ST_ADDR = 3'd2;
  localparam rd_state_t ST_DATA = 3'd3;
  localparam rd_state_t ST_FIN  = 3'd4;

  // log2 of the number of bytes in one data beat.
  function automatic int clog2_bytes(input int data_width);
    return $clog2(data_width / 8);
  endfunction

endpackage

// File: rtl/aximm_burst_len_calc.sv
// Burst length = min(remaining beats, MAX_BURST_LEN, beats left in the 4 KB page).
// Latency: 1 cycle; len_o/arlen_o update on the clock after calc_en_i.
// Backpressure: none; outputs hold until the next calc_en_i.
//
// Ports:
//   calc_en_i    capture a new length this cycle
//   addr_lo_i    low 12 bits of the burst start address (beat aligned)
//   remaining_i  beats still to read in the current pass
//   len_o        burst length in beats (1..MAX_BURST_LEN)
//   arlen_o      len_o - 1, ready to drive ARLEN
module aximm_burst_len_calc #(
  parameter int DATA_BYTES_LOG2 = 0,
  parameter int MAX_BURST_LEN   = 16
) (
  input  logic        ap_clk,
  input  logic        ap_rst_n,
  input  logic        calc_en_i,
  input  logic [11:0] addr_lo_i,
  input  logic [31:0] remaining_i,
  output logic [8:0]  len_o,
  output logic [7:0]  arlen_o
);

  logic [12:0] page_beats;
  logic [8:0]  cap_len;
  logic [8:0]  len_d;
  logic [8:0]  len_m1;
  logic [8:0]  len_q;
  logic [7:0]  arlen_q;

  always_comb begin
    // Beats until the next 4 KB boundary; the address is beat aligned so
    // the shift is exact.
    page_beats = (13'd4096 - {1'b0, addr_lo_i}) >> DATA_BYTES_LOG2;
    cap_len    = (remaining_i < 32'(MAX_BURST_LEN)) ? remaining_i[8:0]
                                                     : 9'(MAX_BURST_LEN);
    len_d      = (page_beats < {4'b0000, cap_len}) ? page_beats[8:0] : cap_len;
    len_m1     = len_d - 9'd1;
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      len_q   <= 9'd0;
      arlen_q <= 8'd0;
    end else if (calc_en_i) begin
      len_q   <= len_d;
      arlen_q <= len_m1[7:0];
    end
  end

  assign len_o   = len_q;
  assign arlen_o = arlen_q;

endmodule

// File: rtl/aximm_burst_reader.sv
// AXI4 read master: streams size bytes from base_addr, times passes, into a FIFO.
// Latency: start -> first AR 2 cycles; R beats pushed combinationally in the accept cycle.
// Backpressure: RREADY = !fifo_full in DATA; one AR outstanding, next AR only after last beat.
//
// Ports:
//   ap_start/ap_ready/ap_done/ap_idle  job control handshake
//   base_addr, size, times             job description, latched on acceptance
//   err                                sticky RRESP / RLAST error for the current job
//   m_axi_AR*, m_axi_R*                AXI4 read address / data channels
//   fifo_wr_en, fifo_wr_data, fifo_full  downstream write-side FIFO
module aximm_burst_reader
  import aximm_pkg::*;
#(
  parameter int ADDR_WIDTH    = 64,
  parameter int DATA_WIDTH    = 8,
  parameter int ID_WIDTH      = 1,
  parameter int MAX_BURST_LEN = 16
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst_n,
  input  logic                  ap_start,
  output logic                  ap_ready,
  output logic                  ap_done,
  output logic                  ap_idle,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [31:0]           size,
  input  logic [31:0]           times,
  output logic                  err,
  output logic                  m_axi_ARVALID,
  input  logic                  m_axi_ARREADY,
  output logic [ADDR_WIDTH-1:0] m_axi_ARADDR,
  output logic [ID_WIDTH-1:0]   m_axi_ARID,
  output logic [7:0]            m_axi_ARLEN,
  output logic [2:0]            m_axi_ARSIZE,
  output logic [1:0]            m_axi_ARBURST,
  output logic [3:0]            m_axi_ARCACHE,
  output logic [2:0]            m_axi_ARPROT,
  input  logic                  m_axi_RVALID,
  output logic                  m_axi_RREADY,
  input  logic [DATA_WIDTH-1:0] m_axi_RDATA,
  input  logic                  m_axi_RLAST,
  input  logic [1:0]            m_axi_RRESP,
  output logic                  fifo_wr_en,
  output logic [DATA_WIDTH-1:0] fifo_wr_data,
  input  logic                  fifo_full
);

  localparam int DATA_BYTES_LOG2 = clog2_bytes(DATA_WIDTH);

  rd_state_t             state_q,    state_d;
  logic [ADDR_WIDTH-1:0] base_q,     base_d;
  logic [ADDR_WIDTH-1:0] addr_q,     addr_d;
  logic [ADDR_WIDTH-1:0] araddr_q,   araddr_d;
  logic [31:0]           bpp_q,      bpp_d;
  logic [31:0]           rem_q,      rem_d;
  logic [31:0]           passes_q,   passes_d;
  logic [8:0]            beat_cnt_q, beat_cnt_d;
  logic                  err_q,      err_d;

  logic [8:0]            burst_len;
  logic [7:0]            burst_arlen;
  logic [31:0]           start_beats;
  logic [31:0]           rem_after;
  logic [ADDR_WIDTH-1:0] burst_bytes;
  logic                  r_accept;
  logic                  last_beat;

  aximm_burst_len_calc #(
    .DATA_BYTES_LOG2 (DATA_BYTES_LOG2),
    .MAX_BURST_LEN   (MAX_BURST_LEN)
  ) u_len_calc (
    .ap_clk      (ap_clk),
    .ap_rst_n    (ap_rst_n),
    .calc_en_i   (state_q == ST_CALC),
    .addr_lo_i   (addr_q[11:0]),
    .remaining_i (rem_q),
    .len_o       (burst_len),
    .arlen_o     (burst_arlen)
  );

  assign ap_idle  = (state_q == ST_IDLE);
  assign ap_ready = ap_idle && ap_start;
  assign ap_done  = (state_q == ST_FIN);
  assign err      = err_q;

  assign m_axi_ARVALID = (state_q == ST_ADDR);
  assign m_axi_ARADDR  = araddr_q;
  assign m_axi_ARLEN   = burst_arlen;
  assign m_axi_ARID    = '0;
  assign m_axi_ARSIZE  = 3'(DATA_BYTES_LOG2);
  assign m_axi_ARBURST = AXI_BURST_INCR;
  assign m_axi_ARCACHE = AXI_CACHE_DEFAULT;
  assign m_axi_ARPROT  = 3'b000;

  assign m_axi_RREADY = (state_q == ST_DATA) && !fifo_full;
  assign r_accept     = m_axi_RVALID && m_axi_RREADY;
  assign fifo_wr_en   = r_accept;
  assign fifo_wr_data = m_axi_RDATA;

  assign start_beats = size >> DATA_BYTES_LOG2;
  // The burst ends on the beat count; RLAST is only cross-checked.
  assign last_beat   = (beat_cnt_q == (burst_len - 9'd1));
  assign rem_after   = rem_q - 32'(burst_len);
  assign burst_bytes = ADDR_WIDTH'(burst_len) << DATA_BYTES_LOG2;

  always_comb begin
    state_d    = state_q;
    base_d     = base_q;
    addr_d     = addr_q;
    araddr_d   = araddr_q;
    bpp_d      = bpp_q;
    rem_d      = rem_q;
    passes_d   = passes_q;
    beat_cnt_d = beat_cnt_q;
    err_d      = err_q;

    case (state_q)
      ST_IDLE: begin
        if (ap_start) begin
          base_d   = base_addr;
          addr_d   = base_addr;
          bpp_d    = start_beats;
          rem_d    = start_beats;
          passes_d = times;
          err_d    = 1'b0;
          state_d  = (start_beats == 32'd0 || times == 32'd0) ? ST_FIN : ST_CALC;
        end
      end
      ST_CALC: begin
        araddr_d = addr_q;
        state_d  = ST_ADDR;
      end
      ST_ADDR: begin
        if (m_axi_ARREADY) begin
          beat_cnt_d = 9'd0;
          state_d    = ST_DATA;
        end
      end
      ST_DATA: begin
        if (r_accept) begin
          beat_cnt_d = beat_cnt_q + 9'd1;
          if (m_axi_RRESP != AXI_RESP_OKAY) err_d = 1'b1;
          if (m_axi_RLAST != last_beat)     err_d = 1'b1;
          if (last_beat) begin
            addr_d = addr_q + burst_bytes;
            rem_d  = rem_after;
            if (rem_after != 32'd0) begin
              state_d = ST_CALC;
            end else if (passes_q > 32'd1) begin
              passes_d = passes_q - 32'd1;
              addr_d   = base_q;
              rem_d    = bpp_q;
              state_d  = ST_CALC;
            end else begin
              state_d = ST_FIN;
            end
          end
        end
      end
      ST_FIN:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state_q    <= ST_IDLE;
      base_q     <= '0;
      addr_q     <= '0;
      araddr_q   <= '0;
      bpp_q      <= 32'd0;
      rem_q      <= 32'd0;
      passes_q   <= 32'd0;
      beat_cnt_q <= 9'd0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      base_q     <= base_d;
      addr_q     <= addr_d;
      araddr_q   <= araddr_d;
      bpp_q      <= bpp_d;
      rem_q      <= rem_d;
      passes_q   <= passes_d;
      beat_cnt_q <= beat_cnt_d;
      err_q      <= err_d;
    end
  end

endmodule

// File: tb/tb_aximm_burst_reader.sv
module tb_aximm_burst_reader;

  logic        ap_clk = 1'b0;
  logic        ap_rst_n;
  logic        ap_start;
  logic        ap_ready, ap_done, ap_idle;
  logic [63:0] base_addr;
  logic [31:0] size, times;
  logic        err;
  logic        m_axi_ARVALID, m_axi_ARREADY;
  logic [63:0] m_axi_ARADDR;
  logic [0:0]  m_axi_ARID;
  logic [7:0]  m_axi_ARLEN;
  logic [2:0]  m_axi_ARSIZE;
  logic [1:0]  m_axi_ARBURST;
  logic [3:0]  m_axi_ARCACHE;
  logic [2:0]  m_axi_ARPROT;
  logic        m_axi_RVALID, m_axi_RREADY;
  logic [7:0]  m_axi_RDATA;
  logic        m_axi_RLAST;
  logic [1:0]  m_axi_RRESP;
  logic        fifo_wr_en;
  logic [7:0]  fifo_wr_data;
  logic        fifo_full;

  always #5 ap_clk = ~ap_clk;

  aximm_burst_reader dut (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n),
    .ap_start(ap_start), .ap_ready(ap_ready), .ap_done(ap_done), .ap_idle(ap_idle),
    .base_addr(base_addr), .size(size), .times(times), .err(err),
    .m_axi_ARVALID(m_axi_ARVALID), .m_axi_ARREADY(m_axi_ARREADY),
    .m_axi_ARADDR(m_axi_ARADDR), .m_axi_ARID(m_axi_ARID), .m_axi_ARLEN(m_axi_ARLEN),
    .m_axi_ARSIZE(m_axi_ARSIZE), .m_axi_ARBURST(m_axi_ARBURST),
    .m_axi_ARCACHE(m_axi_ARCACHE), .m_axi_ARPROT(m_axi_ARPROT),
    .m_axi_RVALID(m_axi_RVALID), .m_axi_RREADY(m_axi_RREADY),
    .m_axi_RDATA(m_axi_RDATA), .m_axi_RLAST(m_axi_RLAST), .m_axi_RRESP(m_axi_RRESP),
    .fifo_wr_en(fifo_wr_en), .fifo_wr_data(fifo_wr_data), .fifo_full(fifo_full)
  );

  int n_cmp = 0;
  int n_fail = 0;

  // Observation state filled in by the slave/monitor process.
  logic [7:0]  push_q[$];
  logic [63:0] ara_q[$];
  logic [7:0]  arl_q[$];
  int done_cnt, done_push, err_first, arv_cycles, bp_viol;
  int beat_idx, slverr_beat, rlast_early_beat;
  bit drop_final_rlast, bp_mode;

  function automatic logic [7:0] mem_byte(input logic [63:0] a);
    return a[7:0] ^ {a[11:8], a[15:12]};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Zero-wait AXI slave plus monitor. Drives at the falling edge, then samples
  // the settled handshakes that will fire at the next rising edge.
  initial begin : env
    bit          burst_act, ar_fire, r_fire;
    logic [63:0] cur_addr;
    int          beats_left, cyc;
    burst_act = 0; ar_fire = 0; r_fire = 0; cur_addr = '0; beats_left = 0; cyc = 0;
    m_axi_ARREADY = 1'b0; m_axi_RVALID = 1'b0; m_axi_RDATA = '0;
    m_axi_RLAST = 1'b0; m_axi_RRESP = 2'b00; fifo_full = 1'b0;
    forever begin
      @(negedge ap_clk);
      if (!ap_rst_n) begin
        burst_act = 0; ar_fire = 0; r_fire = 0;
      end else begin
        if (ar_fire) begin
          burst_act  = 1;
          cur_addr   = ara_q[$];
          beats_left = int'(arl_q[$]) + 1;
        end
        if (r_fire) begin
          cur_addr++; beats_left--; beat_idx++;
          if (beats_left == 0) burst_act = 0;
        end
        if (err && err_first < 0) err_first = push_q.size();
      end
      cyc++;
      fifo_full     = bp_mode ? ((cyc % 4) != 0) : 1'b0;
      m_axi_ARREADY = 1'b1;
      if (burst_act) begin
        m_axi_RVALID = 1'b1;
        m_axi_RDATA  = mem_byte(cur_addr);
        m_axi_RLAST  = (beats_left == 1);
        if (beat_idx == rlast_early_beat) m_axi_RLAST = 1'b1;
        if (drop_final_rlast && beats_left == 1) m_axi_RLAST = 1'b0;
        m_axi_RRESP  = (beat_idx == slverr_beat) ? 2'b10 : 2'b00;
      end else begin
        m_axi_RVALID = 1'b0; m_axi_RDATA = '0; m_axi_RLAST = 1'b0; m_axi_RRESP = 2'b00;
      end
      #1;
      ar_fire = ap_rst_n && m_axi_ARVALID && m_axi_ARREADY;
      r_fire  = ap_rst_n && m_axi_RVALID && m_axi_RREADY;
      if (ar_fire) begin ara_q.push_back(m_axi_ARADDR); arl_q.push_back(m_axi_ARLEN); end
      if (fifo_wr_en) push_q.push_back(fifo_wr_data);
      if (m_axi_RREADY && fifo_full) bp_viol++;
      if (m_axi_ARVALID) arv_cycles++;
      if (ap_done) begin done_cnt++; done_push = push_q.size(); end
    end
  end

  task automatic clear_obs();
    push_q.delete(); ara_q.delete(); arl_q.delete();
    done_cnt = 0; done_push = -1; arv_cycles = 0; bp_viol = 0; beat_idx = 0;
  endtask

  task automatic run_job(input string tag, input logic [63:0] b, input logic [31:0] s,
                         input logic [31:0] t, input int budget);
    @(negedge ap_clk);
    clear_obs();
    base_addr = b; size = s; times = t; ap_start = 1'b1;
    #2;
    check({tag, "_ap_ready"}, ap_ready, 1);
    @(negedge ap_clk);
    ap_start  = 1'b0;
    err_first = -1;
    check({tag, "_err_cleared"}, err, 0);
    for (int i = 0; i < budget && done_cnt == 0; i++) begin
      @(negedge ap_clk); #2;
    end
    repeat (3) @(negedge ap_clk);
    #2;
    check({tag, "_done_once"}, done_cnt, 1);
    check({tag, "_idle_after"}, ap_idle, 1);
  endtask

  task automatic check_ar(input string tag, input int idx, input logic [63:0] a, input logic [7:0] l);
    check({tag, "_araddr"}, (idx < ara_q.size()) ? ara_q[idx] : 64'hDEAD, a);
    check({tag, "_arlen"}, (idx < arl_q.size()) ? 64'(arl_q[idx]) : 64'hDEAD, 64'(l));
  endtask

  task automatic check_data(input string tag, input logic [63:0] b, input int span, input int n);
    int bad;
    bad = 0;
    foreach (push_q[i]) if (push_q[i] !== mem_byte(b + 64'(i % span))) bad++;
    check({tag, "_push_count"}, push_q.size(), n);
    check({tag, "_data_bad"}, bad, 0);
  endtask

  initial begin : main
    int found;
    ap_rst_n = 1'b0; ap_start = 1'b0; base_addr = '0; size = '0; times = '0;
    slverr_beat = -1; rlast_early_beat = -1; drop_final_rlast = 0; bp_mode = 0;
    err_first = -1;
    clear_obs();

    // Reset state
    repeat (3) @(negedge ap_clk);
    #2;
    check("rst_arvalid", m_axi_ARVALID, 0);
    check("rst_rready", m_axi_RREADY, 0);
    check("rst_araddr", m_axi_ARADDR, 0);
    check("rst_arlen", m_axi_ARLEN, 0);
    check("rst_done", ap_done, 0);
    check("rst_ready", ap_ready, 0);
    check("rst_idle", ap_idle, 1);
    check("rst_err", err, 0);
    check("const_arsize", m_axi_ARSIZE, 0);
    check("const_arburst", m_axi_ARBURST, 2'b01);
    check("const_arcache", m_axi_ARCACHE, 4'b0011);
    check("const_arprot", m_axi_ARPROT, 0);
    check("const_arid", m_axi_ARID, 0);
    ap_rst_n = 1'b1;

    // Split by MAX_BURST_LEN
    run_job("t1", 64'h1000, 32'd40, 32'd1, 400);
    check("t1_ar_count", ara_q.size(), 3);
    check_ar("t1_ar0", 0, 64'h1000, 8'd15);
    check_ar("t1_ar1", 1, 64'h1010, 8'd15);
    check_ar("t1_ar2", 2, 64'h1020, 8'd7);
    check_data("t1", 64'h1000, 40, 40);
    check("t1_err", err, 0);

    // 4 KB boundary split
    run_job("t2", 64'h0FF8, 32'd16, 32'd1, 400);
    check("t2_ar_count", ara_q.size(), 2);
    check_ar("t2_ar0", 0, 64'h0FF8, 8'd7);
    check_ar("t2_ar1", 1, 64'h1000, 8'd7);
    check_data("t2", 64'h0FF8, 16, 16);

    // FIFO backpressure, full 3 of every 4 cycles
    bp_mode = 1;
    run_job("t3", 64'h2000, 32'd40, 32'd1, 1000);
    bp_mode = 0;
    check("t3_rready_while_full", bp_viol, 0);
    check("t3_ar_count", ara_q.size(), 3);
    check_data("t3", 64'h2000, 40, 40);

    // Repeated passes
    run_job("t4", 64'h0200, 32'd4, 32'd3, 400);
    check("t4_ar_count", ara_q.size(), 3);
    check_ar("t4_ar0", 0, 64'h0200, 8'd3);
    check_ar("t4_ar1", 1, 64'h0200, 8'd3);
    check_ar("t4_ar2", 2, 64'h0200, 8'd3);
    check_data("t4", 64'h0200, 4, 12);
    check("t4_done_after_last_push", done_push, 12);

    // Empty jobs: done within 2 cycles, no AR issued
    run_job("t5a", 64'h0300, 32'd0, 32'd1, 2);
    check("t5a_no_arvalid", arv_cycles, 0);
    check("t5a_no_push", push_q.size(), 0);
    run_job("t5b", 64'h0300, 32'd8, 32'd0, 2);
    check("t5b_no_arvalid", arv_cycles, 0);

    // SLVERR on beat 2, early RLAST on beat 5, 16-beat burst
    slverr_beat = 2; rlast_early_beat = 5;
    run_job("t6a", 64'h3000, 32'd16, 32'd1, 400);
    slverr_beat = -1; rlast_early_beat = -1;
    check("t6a_ar_count", ara_q.size(), 1);
    check_data("t6a", 64'h3000, 16, 16);
    check("t6a_err", err, 1);
    check("t6a_err_from_beat2", err_first, 3);

    // Early RLAST alone; err must also be cleared by this start
    rlast_early_beat = 5;
    run_job("t6b", 64'h3100, 32'd16, 32'd1, 400);
    rlast_early_beat = -1;
    check("t6b_err", err, 1);
    check("t6b_err_from_beat5", err_first, 6);
    check_data("t6b", 64'h3100, 16, 16);

    // Missing RLAST on the final beat
    drop_final_rlast = 1;
    run_job("t6c", 64'h3200, 32'd8, 32'd1, 400);
    drop_final_rlast = 0;
    check("t6c_err", err, 1);
    check("t6c_err_at_end", err_first, 8);

    // Clean job clears err
    run_job("t6d", 64'h3300, 32'd8, 32'd1, 400);
    check("t6d_err", err, 0);

    // Reset in the middle of the DATA phase
    @(negedge ap_clk);
    clear_obs();
    base_addr = 64'h4000; size = 32'd40; times = 32'd1; ap_start = 1'b1;
    @(negedge ap_clk);
    ap_start = 1'b0;
    found = 0;
    for (int i = 0; i < 60 && found == 0; i++) begin
      @(negedge ap_clk); #2;
      if (m_axi_RREADY && push_q.size() >= 2) found = 1;
    end
    check("t7_reached_data", found, 1);
    ap_rst_n = 1'b0;
    #1;
    check("t7_arvalid_async", m_axi_ARVALID, 0);
    check("t7_rready_async", m_axi_RREADY, 0);
    check("t7_idle_in_reset", ap_idle, 1);
    repeat (2) @(negedge ap_clk);
    ap_rst_n = 1'b1;
    @(negedge ap_clk); #2;
    check("t7_idle_after", ap_idle, 1);
    check("t7_err_after", err, 0);
    run_job("t7r", 64'h0500, 32'd4, 32'd1, 400);
    check_ar("t7r_ar0", 0, 64'h0500, 8'd3);
    check_data("t7r", 64'h0500, 4, 4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
